// File: rtl/fp32_to_int_seq_if.sv
// Handshake bundle between the FP result bus, the fp32->int converter and its integer consumer.
// Latency: none (wires only).
// Backpressure: valid/ready on both the operand side and the result side.
interface fp32_to_int_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     a;
    logic            is_signed;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            overflow;
    logic            underflow;
    logic            exception;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a, is_signed, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, exception
    );

    // The converter itself.
    modport slave (
        input  in_valid, a, is_signed, out_ready,
        output in_ready, out_valid, result, overflow, underflow, exception
    );
endinterface

// File: rtl/fp32_to_int_seq.sv
// Multi-cycle IEEE-754 single -> saturated signed/unsigned XLEN integer, 1-bit-per-cycle aligner.
// Latency: 1 cycle for NaN/Inf/zero/|a|<1, otherwise |e-23|+2 cycles after accept.
// Backpressure: one operand in flight; in_ready only in IDLE, result held until out_ready.
// Optional build macro FP2INT_ROUND_NEAREST_EN: round to nearest-even instead of truncation.
module fp32_to_int_seq #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    fp32_to_int_seq_if.slave  bus
);
    // Magnitude register: 24 significand bits plus XLEN bits of headroom for left shifts.
    localparam int MW = XLEN + 24;

`ifdef FP2INT_ROUND_NEAREST_EN
    // 0.5 <= |a| < 1 can round up to 1, so it must go through the aligner.
    localparam logic [7:0] LOW_EXP = 8'd126;
`else
    localparam logic [7:0] LOW_EXP = 8'd127;
`endif

    localparam logic [XLEN-1:0] POS_MAX = {1'b0, {(XLEN-1){1'b1}}};
    localparam logic [XLEN-1:0] NEG_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SHIFT, PACK, DONE} state_t;

    state_t          state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [MW-1:0]   mag_q, mag_d;
    logic            left_q, left_d;
    logic            ovf_q, ovf_d;        // a 1 was shifted past the top of mag_q
    logic            neg_q, neg_d;
    logic            sgn_q, sgn_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic            exception_q, exception_d;
    logic            out_valid_q, out_valid_d;
`ifdef FP2INT_ROUND_NEAREST_EN
    logic            guard_q, guard_d;
    logic            sticky_q, sticky_d;
    logic            round_inc;
`endif

    logic [7:0]      exp_w;
    logic [22:0]     frac_w;
    logic [MW:0]     mag_r;               // magnitude after rounding, one carry bit wider
    logic            big;                 // rounded magnitude >= 2^XLEN

    assign exp_w  = bus.a[30:23];
    assign frac_w = bus.a[22:0];

    // Rounded magnitude and the coarse out-of-range indication used in PACK.
    always_comb begin
`ifdef FP2INT_ROUND_NEAREST_EN
        round_inc = guard_q & (sticky_q | mag_q[0]);
        mag_r     = {1'b0, mag_q} + {{MW{1'b0}}, round_inc};
`else
        mag_r     = {1'b0, mag_q};
`endif
        big = ovf_q | (|mag_r[MW:XLEN]);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mag_q       <= '0;
            left_q      <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            sgn_q       <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            exception_q <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FP2INT_ROUND_NEAREST_EN
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            left_q      <= left_d;
            ovf_q       <= ovf_d;
            neg_q       <= neg_d;
            sgn_q       <= sgn_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            exception_q <= exception_d;
            out_valid_q <= out_valid_d;
`ifdef FP2INT_ROUND_NEAREST_EN
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
`endif
        end
    end

    // Next-state: classify on accept, align one bit per cycle, round/saturate, hold until taken.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        left_d      = left_q;
        ovf_d       = ovf_q;
        neg_d       = neg_q;
        sgn_d       = sgn_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        exception_d = exception_q;
        out_valid_d = out_valid_q;
`ifdef FP2INT_ROUND_NEAREST_EN
        guard_d     = guard_q;
        sticky_d    = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    result_d    = '0;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    exception_d = 1'b0;
                    neg_d       = bus.a[31];
                    sgn_d       = bus.is_signed;
                    ovf_d       = 1'b0;
                    mag_d       = {{XLEN{1'b0}}, 1'b1, frac_w};
`ifdef FP2INT_ROUND_NEAREST_EN
                    guard_d     = 1'b0;
                    sticky_d    = 1'b0;
`endif
                    if (exp_w == 8'hFF) begin
                        exception_d = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                        if (frac_w != '0)
                            result_d = bus.is_signed ? POS_MAX : ONES;
                        else if (!bus.a[31])
                            result_d = bus.is_signed ? POS_MAX : ONES;
                        else
                            result_d = bus.is_signed ? NEG_MIN : '0;
                    end else if (exp_w < LOW_EXP) begin
                        // Zero, denormal or too small: +/-0 is exact, everything else underflows.
                        underflow_d = |bus.a[30:0];
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (exp_w == 8'd150) begin
                        state_d = PACK;
                    end else if (exp_w > 8'd150) begin
                        left_d  = 1'b1;
                        cnt_d   = 7'(exp_w - 8'd150);
                        state_d = SHIFT;
                    end else begin
                        left_d  = 1'b0;
                        cnt_d   = 7'(8'd150 - exp_w);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (left_q) begin
                    mag_d = {mag_q[MW-2:0], 1'b0};
                    ovf_d = ovf_q | mag_q[MW-1];
                end else begin
                    mag_d = {1'b0, mag_q[MW-1:1]};
`ifdef FP2INT_ROUND_NEAREST_EN
                    guard_d  = mag_q[0];
                    sticky_d = sticky_q | guard_q;
`endif
                end
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1)
                    state_d = PACK;
            end
            PACK: begin
                out_valid_d = 1'b1;
                state_d     = DONE;
                overflow_d  = 1'b0;
                if (sgn_q) begin
                    if (!neg_q) begin
                        if (big || mag_r[XLEN-1]) begin
                            result_d   = POS_MAX;
                            overflow_d = 1'b1;
                        end else begin
                            result_d = mag_r[XLEN-1:0];
                        end
                    end else begin
                        // -2^(XLEN-1) itself is representable.
                        if (big || (mag_r[XLEN-1] && (|mag_r[XLEN-2:0]))) begin
                            result_d   = NEG_MIN;
                            overflow_d = 1'b1;
                        end else begin
                            result_d = ~mag_r[XLEN-1:0] + ONE;
                        end
                    end
                end else begin
                    if (!neg_q) begin
                        if (big) begin
                            result_d   = ONES;
                            overflow_d = 1'b1;
                        end else begin
                            result_d = mag_r[XLEN-1:0];
                        end
                    end else begin
                        // Negative values clamp to 0; only a rounded-to-zero magnitude is exact.
                        result_d   = '0;
                        overflow_d = big | (|mag_r[XLEN-1:0]);
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.exception = exception_q;

endmodule

// File: tb/tb_fp32_to_int_seq.sv
// Directed-vector scoreboard bench for fp32_to_int_seq.
// Driver pushes expected result/flags/latency per operand; monitor pops and compares on out_valid.
// Covers specials, underflow, saturation boundaries, stalls in DONE and reset mid-shift.
module tb_fp32_to_int_seq;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fp32_to_int_seq_if #(.XLEN(XLEN)) bus ();

    fp32_to_int_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        uf;
        logic        ex;
        int          lat;
        int          acc;
        int          stall;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Monitor: pop on the first cycle of each out_valid, then optionally stall and check stability.
    initial begin : mon
        bit   active;
        bit   rel;
        int   hold;
        exp_t cur;
        active = 0;
        rel    = 0;
        hold   = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
                rel    = 0;
                bus.out_ready = 1'b0;
            end else begin
                if (rel) begin
                    active = 0;
                    rel    = 0;
                    bus.out_ready = 1'b0;
                end
                if (bus.out_valid && !active) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got result %0h with empty scoreboard", bus.result);
                    end else begin
                        cur = q.pop_front();
                        check({cur.name, ".result"}, 64'(bus.result), 64'(cur.res));
                        check({cur.name, ".overflow"}, 64'(bus.overflow), 64'(cur.ov));
                        check({cur.name, ".underflow"}, 64'(bus.underflow), 64'(cur.uf));
                        check({cur.name, ".exception"}, 64'(bus.exception), 64'(cur.ex));
                        check({cur.name, ".latency"}, 64'(cyc - cur.acc), 64'(cur.lat));
                        active = 1;
                        hold   = cur.stall;
                        if (hold == 0) begin
                            bus.out_ready = 1'b1;
                            rel = 1;
                        end
                    end
                end else if (active && !rel) begin
                    check({cur.name, ".stall_valid"}, 64'(bus.out_valid), 64'd1);
                    check({cur.name, ".stall_result"}, 64'(bus.result), 64'(cur.res));
                    check({cur.name, ".stall_flags"},
                          64'({bus.overflow, bus.underflow, bus.exception}),
                          64'({cur.ov, cur.uf, cur.ex}));
                    check({cur.name, ".stall_in_ready"}, 64'(bus.in_ready), 64'd0);
                    hold--;
                    if (hold <= 0) begin
                        bus.out_ready = 1'b1;
                        rel = 1;
                    end
                end
            end
        end
    end

    // Present one operand once the converter is idle; optionally register its expectation.
    task automatic issue(input string nm, input logic [31:0] a, input logic sgn,
                         input logic [31:0] res, input logic ov, input logic uf, input logic ex,
                         input int lat, input int stall, input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL %s.in_ready_timeout: in_ready stayed 0 for %0d cycles", nm, n);
        end else begin
            bus.a         = a;
            bus.is_signed = sgn;
            bus.in_valid  = 1'b1;
            if (push) begin
                e.res   = res;
                e.ov    = ov;
                e.uf    = uf;
                e.ex    = ex;
                e.lat   = lat;
                e.acc   = cyc;
                e.stall = stall;
                e.name  = nm;
                q.push_back(e);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        int w;
        w = 0;
        while ((q.size() != 0 || bus.out_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s.drain_timeout: %0d results still pending", nm, q.size());
        end
    endtask

    initial begin : main
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.is_signed = 1'b0;

        #2 rst_n = 1'b0;
        #20;
        check("reset.out_valid", 64'(bus.out_valid), 64'd0);
        check("reset.in_ready", 64'(bus.in_ready), 64'd1);
        check("reset.result", 64'(bus.result), 64'd0);
        check("reset.flags", 64'({bus.overflow, bus.underflow, bus.exception}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // name, a, signed, result, ov, uf, ex, latency, stall, push
`ifdef FP2INT_ROUND_NEAREST_EN
        issue("p1_5",      32'h3FC00000, 1'b1, 32'h00000002, 0, 0, 0, 25, 0, 1);
        issue("half",      32'h3F000000, 1'b1, 32'h00000000, 0, 0, 0, 26, 0, 1);
`else
        issue("p1_5",      32'h3FC00000, 1'b1, 32'h00000001, 0, 0, 0, 25, 0, 1);
        issue("half",      32'h3F000000, 1'b1, 32'h00000000, 0, 1, 0, 1,  0, 1);
`endif
        issue("m123",      32'hC2F60000, 1'b1, 32'hFFFFFF85, 0, 0, 0, 19, 0, 1);
        issue("p2_31_s",   32'h4F000000, 1'b1, 32'h7FFFFFFF, 1, 0, 0, 10, 0, 1);
        issue("m2_31_s",   32'hCF000000, 1'b1, 32'h80000000, 0, 0, 0, 10, 0, 1);
        issue("p2_31_u",   32'h4F000000, 1'b0, 32'h80000000, 0, 0, 0, 10, 0, 1);
        issue("nan_s",     32'h7FC00000, 1'b1, 32'h7FFFFFFF, 0, 0, 1, 1,  0, 1);
        issue("ninf_u",    32'hFF800000, 1'b0, 32'h00000000, 0, 0, 1, 1,  0, 1);
        issue("quarter",   32'h3E800000, 1'b1, 32'h00000000, 0, 1, 0, 1,  0, 1);
        issue("mzero",     32'h80000000, 1'b1, 32'h00000000, 0, 0, 0, 1,  0, 1);
        issue("m1_u",      32'hBF800000, 1'b0, 32'h00000000, 1, 0, 0, 25, 0, 1);
        issue("p1_u",      32'h3F800000, 1'b0, 32'h00000001, 0, 0, 0, 25, 0, 1);
        issue("p2_23",     32'h4B000000, 1'b1, 32'h00800000, 0, 0, 0, 2,  0, 1);
        issue("p2_32_u",   32'h4F800000, 1'b0, 32'hFFFFFFFF, 1, 0, 0, 11, 0, 1);
        issue("maxu_fit",  32'h4F7FFFFF, 1'b0, 32'hFFFFFF00, 0, 0, 0, 10, 0, 1);
        issue("huge_s",    32'h7F7FFFFF, 1'b1, 32'h7FFFFFFF, 1, 0, 0, 106, 0, 1);
        issue("mhuge_s",   32'hFF7FFFFF, 1'b1, 32'h80000000, 1, 0, 0, 106, 0, 1);
        issue("below_min", 32'hCF000001, 1'b1, 32'h80000000, 1, 0, 0, 10, 0, 1);
        issue("denorm",    32'h00000001, 1'b1, 32'h00000000, 0, 1, 0, 1,  0, 1);
        issue("pzero",     32'h00000000, 1'b0, 32'h00000000, 0, 0, 0, 1,  0, 1);
        issue("pinf_s",    32'h7F800000, 1'b1, 32'h7FFFFFFF, 0, 0, 1, 1,  0, 1);
        issue("ninf_s",    32'hFF800000, 1'b1, 32'h80000000, 0, 0, 1, 1,  0, 1);
        issue("nan_u",     32'h7FC00000, 1'b0, 32'hFFFFFFFF, 0, 0, 1, 1,  0, 1);
        issue("pinf_u",    32'h7F800000, 1'b0, 32'hFFFFFFFF, 0, 0, 1, 1,  0, 1);

        // Consumer stalls 5+ cycles while the result sits in DONE.
        issue("stall_m123", 32'hC2F60000, 1'b1, 32'hFFFFFF85, 0, 0, 0, 19, 5, 1);
        issue("stall_nan",  32'h7FC00000, 1'b1, 32'h7FFFFFFF, 0, 0, 1, 1,  5, 1);
        drain("pre_reset");

        // Reset in the middle of a long right shift discards the operand.
        issue("aborted", 32'h3F800000, 1'b1, 32'h0, 0, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset.out_valid", 64'(bus.out_valid), 64'd0);
        check("midreset.in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue("post_reset", 32'hC2F60000, 1'b1, 32'hFFFFFF85, 0, 0, 0, 19, 0, 1);
        drain("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
